// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving the shared 16:1 source mux select
module mux_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int NREQ      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  input  logic [NREQ-1:0] req_mask,
  input  logic            out_ready,
  output logic [3:0]      sel,
  output logic [NREQ-1:0] grant,
  output logic            out_valid,
  output logic            busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [3:0]      sel_q, sel_nxt;
  logic [3:0]      ptr_q, ptr_nxt;
  logic [3:0]      beat_q, beat_nxt;
  logic [NREQ-1:0] grant_q, grant_nxt;
  logic [NREQ-1:0] ereq;
  logic [4:0]      win_ptr, win_rel;
  logic [3:0]      rel_ptr;
  logic            beat_last;

  // Returns {found, index}; scanned downward so the smallest offset from base wins.
  function automatic logic [4:0] pick(input logic [NREQ-1:0] r, input logic [3:0] base);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = base + 4'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign ereq      = req & req_mask;
  assign rel_ptr   = sel_q + 4'd1;
  assign win_ptr   = pick(ereq, ptr_q);
  assign win_rel   = pick(ereq, rel_ptr);
  assign beat_last = (beat_q >= 4'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      grant_q <= '0;
    end else begin
      state   <= state_nxt;
      sel_q   <= sel_nxt;
      ptr_q   <= ptr_nxt;
      beat_q  <= beat_nxt;
      grant_q <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    ptr_nxt   = ptr_q;
    beat_nxt  = beat_q;
    grant_nxt = grant_q;
    case (state)
      IDLE: begin
        if (win_ptr[4]) begin
          sel_nxt   = win_ptr[3:0];
          grant_nxt = NREQ'(1) << win_ptr[3:0];
          beat_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (out_ready) begin
          if (lock[sel_q] && ereq[sel_q] && !beat_last) begin
            beat_nxt = beat_q + 4'd1;
          end else begin
            // Release: the finished requester drops to lowest priority for this decision.
            ptr_nxt = rel_ptr;
            if (win_rel[4]) begin
              sel_nxt   = win_rel[3:0];
              grant_nxt = NREQ'(1) << win_rel[3:0];
              beat_nxt  = '0;
            end else begin
              grant_nxt = '0;
              state_nxt = IDLE;
            end
          end
        end else if (!ereq[sel_q]) begin
          ptr_nxt   = rel_ptr;
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign out_valid = (state == GRANT);
  assign busy      = (state == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req, lock, req_mask;
  logic        out_ready;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        out_valid, busy;

  int errors = 0;
  int checks = 0;
  logic [3:0] sb[$];
  logic mon_en = 1'b0;

  mux_rr_arbiter #(.MAX_BURST(4), .NREQ(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .req_mask(req_mask),
    .out_ready(out_ready), .sel(sel), .grant(grant), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Accepted beats are popped against the expected select sequence at the falling edge.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      checks++;
      if (grant !== (out_valid ? (16'h1 << sel) : 16'h0) || busy !== out_valid) begin
        errors++;
        $display("FAIL invariant: grant=%h sel=%0d out_valid=%b busy=%b", grant, sel, out_valid, busy);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: sel=%0d, none expected", sel);
        end else begin
          logic [3:0] exp_sel;
          exp_sel = sb.pop_front();
          if (sel !== exp_sel) begin
            errors++;
            $display("FAIL beat_sel: got %0d expected %0d", sel, exp_sel);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    sb.delete();
    rst_n = 1'b0; req = '0; lock = '0; req_mask = 16'hFFFF; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) step();
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    rst_n = 1'b0; req = 16'hFFFF; lock = '0; req_mask = 16'hFFFF; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (grant !== 16'h0 || out_valid !== 1'b0 || sel !== 4'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: grant=%h out_valid=%b sel=%0d busy=%b, expected 0", grant, out_valid, sel, busy);
      end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (sel !== 4'd0 || grant !== 16'h0001 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: sel=%0d grant=%h out_valid=%b expected 0/0001/1", sel, grant, out_valid);
    end
  endtask

  task automatic test_rr_pair();
    do_reset();
    for (int i = 0; i < 4; i++) begin sb.push_back(4'd0); sb.push_back(4'd15); end
    req = 16'h8001; out_ready = 1'b1;
    step();
    while (sb.size() != 0 && checks < 100000) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_pair_valid: out_valid=%b expected 1", out_valid);
      end
      if (sb.size() != 0) step();
      if (sb.size() == 0) break;
      if (errors > 50) break;
    end
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rr_pair_timeout: %0d beats left, expected 0", sb.size()); end
    out_ready = 1'b0; req = '0;
  endtask

  task automatic test_burst();
    do_reset();
    sb.push_back(4'd0);
    for (int i = 0; i < 4; i++) sb.push_back(4'd3);
    sb.push_back(4'd0);
    req = 16'h0009; lock = 16'h0008; out_ready = 1'b1;
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL burst_timeout: %0d beats left, expected 0", sb.size()); end
    out_ready = 1'b0; req = '0; lock = '0;
  endtask

  task automatic test_stall();
    do_reset();
    req = 16'h0020;
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) step();
    for (int i = 0; i < 10; i++) begin
      req  = 16'h0020 | (16'($urandom) & 16'hFFDF);
      lock = 16'($urandom);
      step();
      checks++;
      if (sel !== 4'd5 || grant !== 16'h0020 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: sel=%0d grant=%h out_valid=%b expected 5/0020/1", sel, grant, out_valid);
      end
    end
    req = 16'h0020; lock = '0;
    sb.push_back(4'd5);
    out_ready = 1'b1;
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stall_timeout: %0d beats left, expected 0", sb.size()); end
    out_ready = 1'b0; req = '0;
  endtask

  task automatic test_abort();
    do_reset();
    req = 16'h0080;
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) step();
    checks++;
    if (sel !== 4'd7 || grant !== 16'h0080) begin
      errors++;
      $display("FAIL abort_grant: sel=%0d grant=%h expected 7/0080", sel, grant);
    end
    req = '0;
    step();
    checks++;
    if (out_valid !== 1'b0 || grant !== 16'h0) begin
      errors++;
      $display("FAIL abort_drop: out_valid=%b grant=%h expected 0/0000", out_valid, grant);
    end
    // ptr now sits at 8, so requester 8 must beat requester 7.
    sb.push_back(4'd8); sb.push_back(4'd7);
    req = 16'h0180; out_ready = 1'b1;
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL abort_timeout: %0d beats left, expected 0", sb.size()); end
    out_ready = 1'b0; req = '0;
  endtask

  task automatic test_mask();
    logic [3:0] order [8];
    order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11};
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) sb.push_back(order[i]);
    req = 16'hFFFF; req_mask = 16'h0F0F; out_ready = 1'b1;
    drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL mask_timeout: %0d beats left, expected 0", sb.size()); end
    out_ready = 1'b0; req = '0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; req_mask = 16'hFFFF; out_ready = 1'b0;
    test_reset();
    test_rr_pair();
    test_burst();
    test_stall();
    test_abort();
    test_mask();
    mon_en = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
